// File: rtl/debounce_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_pkg : shared debounce defaults and counter-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEF_TICK_DIV     = 1000;
  localparam int DEF_STABLE_TICKS = 4;

  // Width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// debounce_bit : two-flop synchroniser, tick-driven agreement counter and
//                stable-level flop for one switch input
// Rev 1.0
// ---------------------------------------------------------------------------
module debounce_bit
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  input  logic i_en,
  input  logic i_tick,
  output logic o_stable,
  output logic o_update
);

  localparam int CW = cnt_width(STABLE_TICKS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(STABLE_TICKS - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_differs;
  logic          w_accept;

  assign w_differs = r_sync ^ r_stable;
  // The tick that completes the run of disagreeing samples commits the new level.
  assign w_accept  = i_tick & w_differs & (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta   <= 1'b0;
      r_sync   <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      if (!i_en) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (!w_differs) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= r_sync;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_stable = r_stable;
  assign o_update = w_accept;

endmodule
`default_nettype wire

// File: rtl/switch_debounce8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// switch_debounce8 : debounced switch bank with change strobe, feeding the
//                    8-to-3 priority encoder x input
// Rev 1.0
// ---------------------------------------------------------------------------
module switch_debounce8
  import debounce_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic             sw_changed,
  output logic             sw_any
);

  localparam int PW = cnt_width(TICK_DIV);
  localparam logic [PW-1:0] C_PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    r_presc;
  logic             r_changed;
  logic             w_tick;
  logic [WIDTH-1:0] w_update;

  assign w_tick = en & (r_presc == C_PRESC_LAST);

  // Prescaler freezes while disabled so the tick phase resumes where it stopped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (sw_raw[gi]),
      .i_en    (en),
      .i_tick  (w_tick),
      .o_stable(sw_stable[gi]),
      .o_update(w_update[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= |w_update;
    end
  end

  assign sw_changed = r_changed;
  assign sw_any     = |sw_stable;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce8.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_switch_debounce8 : directed stimulus with a pulse scoreboard for
//                       switch_debounce8 (TICK_DIV=4, STABLE_TICKS=3)
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_switch_debounce8;

  localparam int WIDTH        = 8;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en     = 1'b0;
  logic [WIDTH-1:0] sw_raw = '0;
  logic [WIDTH-1:0] sw_stable;
  logic             sw_changed;
  logic             sw_any;

  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  switch_debounce8 #(
    .WIDTH       (WIDTH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE_TICKS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_changed(sw_changed),
    .sw_any    (sw_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int prio_enc(input logic [WIDTH-1:0] x);
    for (int b = WIDTH - 1; b >= 0; b--) if (x[b]) return b;
    return 0;
  endfunction

  // Waits for sw_stable==exp; the arrival cycle (counted in edges) must lie in [lo,hi]
  // and coincide with the change pulse.
  task automatic wait_stable(input logic [WIDTH-1:0] exp, input int lo, input int hi,
                             input string name);
    int c = 0;
    for (int k = 1; k <= hi + 2; k++) begin
      @(negedge clk);
      if (sw_stable === exp) begin
        c = k;
        break;
      end
    end
    checks++;
    if (c == 0) begin
      errors++;
      $display("FAIL %s: timeout, sw_stable=0x%0h, expected 0x%0h", name, sw_stable, exp);
    end else begin
      if (c < lo || c > hi) begin
        errors++;
        $display("FAIL %s: latency %0d clk, expected %0d..%0d", name, c, lo, hi);
      end
      check({name, "_pulse"}, {31'b0, sw_changed}, 32'd1);
    end
  endtask

  task automatic drained(input string name);
    check(name, exp_q.size(), 0);
  endtask

  // Monitor: every change pulse must match the next queued expectation.
  initial begin
    logic             prev_changed;
    logic [WIDTH-1:0] e;
    prev_changed = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && sw_changed) begin
        check("changed_twice", {31'b0, prev_changed}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: sw_changed=1 with sw_stable=0x%0h, expected no pulse",
                   sw_stable);
        end else begin
          e = exp_q.pop_front();
          check("pulse_value", sw_stable, e);
          check("pulse_any", {31'b0, sw_any}, {31'b0, |e});
        end
      end
      prev_changed = rst_n & sw_changed;
    end
  end

  initial begin
    // Reset with all switches high
    rst_n  = 1'b0;
    en     = 1'b1;
    sw_raw = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      check("rst_stable", sw_stable, 0);
      check("rst_changed", {31'b0, sw_changed}, 0);
      check("rst_any", {31'b0, sw_any}, 0);
    end
    sw_raw = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clean step to 0x81
    sw_raw = 8'h81;
    exp_q.push_back(8'h81);
    wait_stable(8'h81, 11, 14, "t2_step");
    check("t2_any", {31'b0, sw_any}, 1);
    check("t2_encoder_y", prio_enc(sw_stable), 7);
    repeat (10) @(negedge clk);
    drained("t2_drained");

    // Short pulse on bit 3 (two ticks only)
    sw_raw = 8'h89;
    repeat (8) @(negedge clk);
    sw_raw = 8'h81;
    repeat (24) @(negedge clk);
    check("t3_stable", sw_stable, 8'h81);

    // Bit 5 chatters then settles high
    exp_q.push_back(8'hA1);
    for (int k = 0; k < 20; k++) begin
      sw_raw[5] = ~sw_raw[5];
      @(negedge clk);
    end
    sw_raw[5] = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_stable", sw_stable, 8'hA1);
    drained("t4_drained");

    // Return to all-zero
    sw_raw = 8'h00;
    exp_q.push_back(8'h00);
    wait_stable(8'h00, 11, 14, "fall_step");
    repeat (6) @(negedge clk);

    // Enable dropped mid-count: counters must restart
    sw_raw = 8'h10;
    repeat (10) @(negedge clk);
    en = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_frozen", sw_stable, 8'h00);
    en = 1'b1;
    exp_q.push_back(8'h10);
    wait_stable(8'h10, 9, 12, "t5_reenable");
    repeat (6) @(negedge clk);
    drained("t5_drained");

    // Asynchronous reset clears a non-zero stable vector immediately
    #2 rst_n = 1'b0;
    #1;
    check("async_stable", sw_stable, 8'h00);
    check("async_any", {31'b0, sw_any}, 0);
    sw_raw = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset mid-count, then a fresh full acceptance
    sw_raw = 8'h0F;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_stable", sw_stable, 8'h00);
    check("t6_changed", {31'b0, sw_changed}, 0);
    check("t6_any", {31'b0, sw_any}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(8'h0F);
    wait_stable(8'h0F, 12, 12, "t6_fresh");
    repeat (10) @(negedge clk);
    drained("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
